// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
// Holds the blank nibble code, the all-off anode pattern and the
// leading-zero mask function. Sized for up to MAX_DIGITS digits.
package seg_pkg;

  localparam int MAX_DIGITS = 8;

  // Nibble code that the downstream decoder renders as all segments off.
  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Active-low anodes: all ones turns every digit off.
  localparam logic [MAX_DIGITS-1:0] AN_ALL_OFF = '1;

  // Bit i is set when nibbles i..MAX_DIGITS-1 of value are all zero.
  // Callers zero-extend narrower values. The extra nibbles are zero, so
  // the low DIGITS bits of the mask are the same as for the narrow value.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] value);
    logic [MAX_DIGITS-1:0] m;
    logic                  all_zero;
    m        = '0;
    all_zero = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (value[4*i +: 4] == 4'h0);
      m[i]     = all_zero;
    end
    return m;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Refresh prescaler: emits tick on the last cycle of each digit dwell.
// Ports: clk, rst (sync, active-high), en (0 holds count at 0), tick (combinational from count).
// The count restarts from 0 whenever en is low, so a re-enabled scan gets a full first dwell.
module scan_tick_gen
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int               CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_comb begin
    tick = en && (cnt == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a DIGITS-digit seven-segment display.
// Ports: clk, rst, en, load/din (double-buffered value), lz_blank; outputs bcd, an (active low),
// pending (value waiting for frame boundary), frame (pulse with digit 0 of each new frame).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  lz_blank,
  output logic [3:0]            bcd,
  output logic [DIGITS-1:0]     an,
  output logic                  pending,
  output logic                  frame
);

  localparam int                IDX_W    = $clog2(DIGITS);
  localparam int                VW       = 4 * DIGITS;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

  logic                  tick;
  logic                  boundary;
  logic                  wrapped;
  logic [IDX_W-1:0]      idx;
  logic [VW-1:0]         shadow;
  logic [VW-1:0]         active;
  logic [MAX_DIGITS-1:0] blank_vec;
  logic                  blank_cur;
  logic [3:0]            nib_cur;
  logic [DIGITS-1:0]     an_cur;

  scan_tick_gen #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );

  always_comb begin
    boundary  = tick && (idx == IDX_LAST);
    blank_vec = lz_mask((4*MAX_DIGITS)'(active));
    // Digit 0 always shows, so a zero value still displays a single 0.
    blank_cur = lz_blank && (idx != '0) && blank_vec[idx];
    nib_cur   = active[{idx, 2'b00} +: 4];
    an_cur    = ~(DIGITS'(1) << idx);
  end

  // Digit counter: forced to 0 while disabled so scanning resumes at digit 0.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
  end

  // Double buffer. A load landing on the boundary bypasses the shadow so
  // the new value is not held back a whole extra frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else if (load) begin
      shadow <= din;
      if (boundary) begin
        active  <= din;
        pending <= 1'b0;
      end else begin
        pending <= 1'b1;
      end
    end else if (boundary && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end
  end

  // Marks the cycle where idx has just wrapped to 0; the registered outputs
  // for that digit appear one edge later, so frame lines up with them.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrapped <= 1'b0;
    end else begin
      wrapped <= boundary;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      an    <= AN_ALL_OFF[DIGITS-1:0];
      bcd   <= BCD_BLANK;
      frame <= 1'b0;
    end else begin
      if (blank_cur) begin
        an  <= AN_ALL_OFF[DIGITS-1:0];
        bcd <= BCD_BLANK;
      end else begin
        an  <= an_cur;
        bcd <= nib_cur;
      end
      frame <= wrapped;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with DIGITS=4, REFRESH_DIV=4.
// Reference model tracks scan position as elapsed enabled cycles and the displayed value as an integer.
// Directed scenarios pin literal values; a random phase follows.
module tb_seg_scan_ctrl;

  localparam int D  = 4;
  localparam int RD = 4;
  localparam int FR = D * RD;

  logic        clk = 1'b0;
  logic        rst, en, load, lz_blank;
  logic [15:0] din;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        pending, frame;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // model state
  int          phase  = 0;
  logic [15:0] shown  = '0;
  logic [15:0] queued = '0;
  bit          has_q  = 1'b0;
  logic [3:0]  exp_an   = 4'hF;
  logic [3:0]  exp_bcd  = 4'hF;
  logic        exp_frame = 1'b0;
  logic        exp_pend  = 1'b0;

  seg_scan_ctrl #(
    .DIGITS(D),
    .REFRESH_DIV(RD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .load(load),
    .din(din),
    .lz_blank(lz_blank),
    .bcd(bcd),
    .an(an),
    .pending(pending),
    .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Model: outputs after an edge follow the scan position and displayed value before it.
  always @(posedge clk) begin
    int         d;
    bit         blk;
    bit         bnd;
    logic [3:0] one_hot_n;
    if (rst) begin
      exp_an    = 4'hF;
      exp_bcd   = 4'hF;
      exp_frame = 1'b0;
      exp_pend  = 1'b0;
      phase     = 0;
      shown     = '0;
      queued    = '0;
      has_q     = 1'b0;
    end else begin
      if (en) begin
        d   = (phase / RD) % D;
        blk = lz_blank && (d != 0) && ((shown >> (4 * d)) == 16'h0);
        one_hot_n = ~(4'b0001 << d);
        exp_an    = blk ? 4'hF : one_hot_n;
        exp_bcd   = blk ? 4'hF : 4'((shown >> (4 * d)) & 16'hF);
        exp_frame = (phase != 0) && (phase % FR == 0);
      end else begin
        exp_an    = 4'hF;
        exp_bcd   = 4'hF;
        exp_frame = 1'b0;
      end
      bnd = en && (phase % FR == FR - 1);
      if (load) begin
        queued = din;
        if (bnd) begin
          shown = din;
          has_q = 1'b0;
        end else begin
          has_q = 1'b1;
        end
      end else if (bnd && has_q) begin
        shown = queued;
        has_q = 1'b0;
      end
      phase    = en ? phase + 1 : 0;
      exp_pend = has_q;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("an", 32'(an), 32'(exp_an));
      chk("bcd", 32'(bcd), 32'(exp_bcd));
      chk("frame", 32'(frame), 32'(exp_frame));
      chk("pending", 32'(pending), 32'(exp_pend));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int  waited;
    rst = 1'b1; en = 1'b1; load = 1'b0; din = '0; lz_blank = 1'b0;
    @(posedge clk);
    chk_on = 1'b1;
    cyc(2);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_bcd", 32'(bcd), 32'hF);
    chk("rst_pend", 32'(pending), 32'h0);
    chk("rst_frame", 32'(frame), 32'h0);
    rst = 1'b0;                           // N0

    cyc(1);                               // N1
    chk("first_an", 32'(an), 32'b1110);
    chk("first_bcd", 32'(bcd), 32'h0);
    cyc(4);                               // N5
    chk("scan_an1", 32'(an), 32'b1101);
    cyc(11);                              // N16
    chk("no_first_frame", 32'(frame), 32'h0);
    cyc(1);                               // N17
    chk("frame_2nd", 32'(frame), 32'h1);

    // double buffer
    cyc(1);                               // N18
    load = 1'b1; din = 16'h1234;
    cyc(1);                               // N19
    load = 1'b0;
    chk("pend_rise", 32'(pending), 32'h1);
    chk("db_old_bcd", 32'(bcd), 32'h0);
    cyc(14);                              // N33
    chk("db_frame", 32'(frame), 32'h1);
    chk("db_bcd0", 32'(bcd), 32'h4);
    chk("db_pend0", 32'(pending), 32'h0);
    cyc(4);                               // N37
    chk("db_bcd1", 32'(bcd), 32'h3);

    // blanking
    lz_blank = 1'b1; load = 1'b1; din = 16'h0070;
    cyc(1);                               // N38
    load = 1'b0;
    cyc(11);                              // N49
    chk("lz_d0_bcd", 32'(bcd), 32'h0);
    chk("lz_d0_an", 32'(an), 32'b1110);
    cyc(4);                               // N53
    chk("lz_d1_bcd", 32'(bcd), 32'h7);
    cyc(4);                               // N57
    chk("lz_d2_an", 32'(an), 32'hF);
    chk("lz_d2_bcd", 32'(bcd), 32'hF);

    // load exactly on the boundary cycle
    waited = 0;
    while ((phase % FR) != FR - 1 && waited < 64) begin
      cyc(1);
      waited++;
    end
    chk("align_timeout", 32'(waited < 64), 32'h1);
    load = 1'b1; din = 16'h5678;
    cyc(1);
    load = 1'b0;
    chk("coll_pend", 32'(pending), 32'h0);
    cyc(1);
    chk("coll_frame", 32'(frame), 32'h1);
    chk("coll_bcd", 32'(bcd), 32'h8);

    // enable off for 10 cycles with a load inside the window
    en = 1'b0;
    cyc(1);
    chk("dis_an", 32'(an), 32'hF);
    chk("dis_bcd", 32'(bcd), 32'hF);
    cyc(2);
    load = 1'b1; din = 16'h4321;
    cyc(1);
    load = 1'b0;
    cyc(1);
    chk("dis_pend", 32'(pending), 32'h1);
    cyc(5);
    en = 1'b1;
    cyc(1);
    chk("reen_an", 32'(an), 32'b1110);
    chk("reen_bcd", 32'(bcd), 32'h8);
    cyc(16);
    chk("reen_frame", 32'(frame), 32'h1);
    chk("reen_new", 32'(bcd), 32'h1);

    // random phase
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(299) == 0);
      if ($urandom_range(99) == 0) en = ~en;
      if ($urandom_range(49) == 0) lz_blank = ~lz_blank;
      load = ($urandom_range(11) == 0);
      case ($urandom_range(3))
        0: din = 16'($urandom);
        1: din = 16'($urandom) & 16'h00FF;
        2: din = 16'($urandom) & 16'h000F;
        default: din = 16'($urandom) & 16'h0F0F;
      endcase
      cyc(1);
    end
    rst = 1'b0; load = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
